// File: rtl/rptr_pkg.sv
// Shared helpers for the multi-channel read-pointer controller.
// Gray/binary conversion functions and channel-select width calculation.
package rptr_pkg;

  function automatic int calc_chw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Operate at 32 bits; callers zero-extend and truncate to their width
  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    b[31] = g[31];
    for (int i = 30; i >= 0; i--)
      b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

endpackage

// File: rtl/rptr_chan.sv
// One read-side channel slice: pointers, empty, count, almost-empty, error.
// Almost-empty comparator is built only when RPTR_AEMPTY_EN is defined.
module rptr_chan
  import rptr_pkg::*;
#(
  parameter int ADDRSIZE  = 4,
  parameter int AEMPTY_TH = 2
) (
  input  logic              rclk,
  input  logic              rrst,
  input  logic [ADDRSIZE:0] i_wq,
  input  logic              i_req,
  output logic [ADDRSIZE:0] o_rbin,
  output logic [ADDRSIZE:0] o_rptr,
  output logic [ADDRSIZE:0] o_rcount,
  output logic              o_rempty,
  output logic              o_raempty,
  output logic              o_rerr
);

  localparam int AW = ADDRSIZE + 1;

  logic [AW-1:0] r_rbin;
  logic [AW-1:0] r_rptr;
  logic [AW-1:0] r_rcount;
  logic          r_rempty;
  logic          r_rerr;

  logic          w_hit;
  logic [AW-1:0] w_bnext;
  logic [AW-1:0] w_gnext;
  logic [AW-1:0] w_wbin;
  logic [AW-1:0] w_cnt;

  assign w_hit   = i_req & ~r_rempty;
  assign w_bnext = r_rbin + {{(AW-1){1'b0}}, w_hit};
  assign w_gnext = AW'(bin2gray(32'(w_bnext)));
  assign w_wbin  = AW'(gray2bin(32'(i_wq)));
  assign w_cnt   = w_wbin - w_bnext;

  // Full-width compare keeps empty/full distinct across wrap
  always_ff @(posedge rclk) begin
    if (rrst) begin
      r_rbin   <= '0;
      r_rptr   <= '0;
      r_rcount <= '0;
      r_rempty <= 1'b1;
      r_rerr   <= 1'b0;
    end else begin
      r_rbin   <= w_bnext;
      r_rptr   <= w_gnext;
      r_rcount <= w_cnt;
      r_rempty <= (w_gnext == i_wq);
      r_rerr   <= i_req & r_rempty;
    end
  end

`ifdef RPTR_AEMPTY_EN
  logic r_raempty;

  always_ff @(posedge rclk) begin
    if (rrst) r_raempty <= 1'b1;
    else      r_raempty <= (w_cnt <= AW'(AEMPTY_TH));
  end

  assign o_raempty = r_raempty;
`else
  assign o_raempty = 1'b0;
`endif

  assign o_rbin   = r_rbin;
  assign o_rptr   = r_rptr;
  assign o_rcount = r_rcount;
  assign o_rempty = r_rempty;
  assign o_rerr   = r_rerr;

endmodule

// File: rtl/rptr_empty_mc.sv
// Multi-channel read pointer / empty controller for shared-memory FIFOs.
// Define RPTR_AEMPTY_EN to build the per-channel almost-empty flags.
module rptr_empty_mc
  import rptr_pkg::*;
#(
  parameter int ADDRSIZE  = 4,
  parameter int NCH       = 4,
  parameter int AEMPTY_TH = 2,
  parameter int CHW       = calc_chw(NCH)
) (
  input  logic                        rclk,
  input  logic                        rrst,
  input  logic [NCH*(ADDRSIZE+1)-1:0] rq2_wptr,
  input  logic                        rinc,
  input  logic [CHW-1:0]              rsel,
  output logic [CHW+ADDRSIZE-1:0]     raddr,
  output logic [NCH*(ADDRSIZE+1)-1:0] rptr,
  output logic [NCH-1:0]              rempty,
  output logic [NCH*(ADDRSIZE+1)-1:0] rcount,
  output logic [NCH-1:0]              raempty,
  output logic [NCH-1:0]              rerr
);

  localparam int AW = ADDRSIZE + 1;

  logic [AW-1:0]       w_rbin [NCH];
  logic [ADDRSIZE-1:0] w_lo;

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    logic w_req;

    // Out-of-range rsel never matches, so such reads are dropped
    assign w_req = rinc & (rsel == CHW'(c));

    rptr_chan #(
      .ADDRSIZE  (ADDRSIZE),
      .AEMPTY_TH (AEMPTY_TH)
    ) u_chan (
      .rclk      (rclk),
      .rrst      (rrst),
      .i_wq      (rq2_wptr[c*AW +: AW]),
      .i_req     (w_req),
      .o_rbin    (w_rbin[c]),
      .o_rptr    (rptr[c*AW +: AW]),
      .o_rcount  (rcount[c*AW +: AW]),
      .o_rempty  (rempty[c]),
      .o_raempty (raempty[c]),
      .o_rerr    (rerr[c])
    );
  end

  always_comb begin
    w_lo = '0;
    for (int c = 0; c < NCH; c++)
      if (rsel == CHW'(c))
        w_lo = w_rbin[c][ADDRSIZE-1:0];
  end

  assign raddr = {rsel, w_lo};

endmodule
